// File: rtl/mc_mips_control_if.sv
// Memory handshake between the multicycle MIPS controller (master) and the
// memory system (slave): request, write qualifier and completion strobe.
interface mc_mips_control_if;
   logic mem_req;
   logic mem_we;
   logic mem_ack;

   modport master (
      output mem_req,
      output mem_we,
      input  mem_ack
   );

   modport slave (
      input  mem_req,
      input  mem_we,
      output mem_ack
   );
endinterface

// File: rtl/mc_mips_control.sv
// Multicycle MIPS control FSM with a bus-wait watchdog. Define MC_JAL_JR_EN to
// add the JAL (opcode 0x03) and JR (R-type funct 0x08) instruction paths.
module mc_mips_control #(
   parameter int MAX_WAIT = 15,
   parameter int WAIT_W   = 4
) (
   input  logic                      clk,
   input  logic                      reset,
   mc_mips_control_if.master         mem,
   input  logic [5:0]                opcode,
   input  logic [5:0]                funct,
   input  logic                      zero,
   output logic                      iord,
   output logic                      irwrite,
   output logic                      pcwrite,
   output logic                      regwrite,
   output logic                      memtoreg,
   output logic                      alusrca,
   output logic [1:0]                alusrcb,
   output logic [1:0]                pcsrc,
   output logic [1:0]                regdst,
   output logic [2:0]                alucontrol,
   output logic [3:0]                state,
   output logic                      bus_err
);

   typedef enum logic [3:0] {
      S_FETCH  = 4'd0,
      S_DECODE = 4'd1,
      S_MEMADR = 4'd2,
      S_MEMRD  = 4'd3,
      S_MEMWB  = 4'd4,
      S_MEMWR  = 4'd5,
      S_EXEC   = 4'd6,
      S_ALUWB  = 4'd7,
      S_BRANCH = 4'd8,
      S_ADDIEX = 4'd9,
      S_ADDIWB = 4'd10,
      S_JUMP   = 4'd11,
      S_JAL    = 4'd12,
      S_JR     = 4'd13,
      S_ERR    = 4'd15
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_J     = 6'h02;
`ifdef MC_JAL_JR_EN
   localparam logic [5:0] OP_JAL   = 6'h03;
   localparam logic [5:0] FN_JR    = 6'h08;
`endif

   localparam logic [5:0] FN_ADD   = 6'h20;
   localparam logic [5:0] FN_SUB   = 6'h22;
   localparam logic [5:0] FN_AND   = 6'h24;
   localparam logic [5:0] FN_OR    = 6'h25;
   localparam logic [5:0] FN_SLT   = 6'h2A;

   localparam logic [2:0] ALU_ADD  = 3'b010;
   localparam logic [2:0] ALU_SUB  = 3'b110;
   localparam logic [2:0] ALU_AND  = 3'b000;
   localparam logic [2:0] ALU_OR   = 3'b001;
   localparam logic [2:0] ALU_SLT  = 3'b111;

   localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MAX_WAIT);

   state_t            state_q, state_d;
   logic [WAIT_W-1:0] wait_q,  wait_d;
   logic              ack_seen;
   logic              wait_expired;

   // An ack only counts while a request is actually outstanding.
   assign ack_seen     = mem.mem_req & mem.mem_ack;
   assign wait_expired = (wait_q == WAIT_LIMIT);

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_FETCH;
         wait_q  <= '0;
      end else begin
         state_q <= state_d;
         wait_q  <= wait_d;
      end
   end

   // NOTE: every combinational output gets a default first so no path through
   // the case statements leaves a value unassigned and infers a latch.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_FETCH: begin
            if (ack_seen)          state_d = S_DECODE;
            else if (wait_expired) state_d = S_ERR;
         end
         S_DECODE: begin
            case (opcode)
               OP_LW, OP_SW: state_d = S_MEMADR;
`ifdef MC_JAL_JR_EN
               OP_RTYPE:     state_d = (funct == FN_JR) ? S_JR : S_EXEC;
               OP_JAL:       state_d = S_JAL;
`else
               OP_RTYPE:     state_d = S_EXEC;
`endif
               OP_BEQ:       state_d = S_BRANCH;
               OP_ADDI:      state_d = S_ADDIEX;
               OP_J:         state_d = S_JUMP;
               default:      state_d = S_FETCH;
            endcase
         end
         S_MEMADR: state_d = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
         S_MEMRD: begin
            if (ack_seen)          state_d = S_MEMWB;
            else if (wait_expired) state_d = S_ERR;
         end
         S_MEMWR: begin
            if (ack_seen)          state_d = S_FETCH;
            else if (wait_expired) state_d = S_ERR;
         end
         S_EXEC:   state_d = S_ALUWB;
         S_ADDIEX: state_d = S_ADDIWB;
         S_MEMWB, S_ALUWB, S_BRANCH, S_ADDIWB,
         S_JUMP, S_JAL, S_JR: state_d = S_FETCH;
         S_ERR:    state_d = S_ERR;
         default:  state_d = S_FETCH;
      endcase
   end

   // Watchdog restarts on every state change (covers entry to each memory
   // state) and on a completed access; it only advances while waiting.
   always_comb begin
      wait_d = wait_q;
      if (ack_seen || (state_d != state_q)) begin
         wait_d = '0;
      end else if (mem.mem_req) begin
         wait_d = wait_q + WAIT_W'(1);
      end
   end

   always_comb begin
      mem.mem_req = 1'b0;
      mem.mem_we  = 1'b0;
      iord        = 1'b0;
      irwrite     = 1'b0;
      pcwrite     = 1'b0;
      regwrite    = 1'b0;
      memtoreg    = 1'b0;
      alusrca     = 1'b0;
      alusrcb     = 2'b00;
      pcsrc       = 2'b00;
      regdst      = 2'b00;
      alucontrol  = 3'b000;
      case (state_q)
         S_FETCH: begin
            mem.mem_req = 1'b1;
            alusrcb     = 2'b01;
            alucontrol  = ALU_ADD;
            irwrite     = ack_seen;
            pcwrite     = ack_seen;
         end
         S_DECODE: begin
            alusrcb    = 2'b11;
            alucontrol = ALU_ADD;
         end
         S_MEMADR, S_ADDIEX: begin
            alusrca    = 1'b1;
            alusrcb    = 2'b10;
            alucontrol = ALU_ADD;
         end
         S_MEMRD: begin
            mem.mem_req = 1'b1;
            iord        = 1'b1;
         end
         S_MEMWB: begin
            regwrite = 1'b1;
            memtoreg = 1'b1;
         end
         S_MEMWR: begin
            mem.mem_req = 1'b1;
            mem.mem_we  = 1'b1;
            iord        = 1'b1;
         end
         S_EXEC: begin
            alusrca = 1'b1;
            case (funct)
               FN_SUB:  alucontrol = ALU_SUB;
               FN_AND:  alucontrol = ALU_AND;
               FN_OR:   alucontrol = ALU_OR;
               FN_SLT:  alucontrol = ALU_SLT;
               FN_ADD:  alucontrol = ALU_ADD;
               default: alucontrol = ALU_ADD;
            endcase
         end
         S_ALUWB: begin
            regwrite = 1'b1;
            regdst   = 2'b01;
         end
         S_BRANCH: begin
            alusrca    = 1'b1;
            alucontrol = ALU_SUB;
            pcsrc      = 2'b01;
            pcwrite    = zero;
         end
         S_ADDIWB: begin
            regwrite = 1'b1;
         end
         S_JUMP: begin
            pcsrc   = 2'b10;
            pcwrite = 1'b1;
         end
         S_JAL: begin
            pcsrc    = 2'b10;
            pcwrite  = 1'b1;
            regwrite = 1'b1;
            regdst   = 2'b10;
         end
         S_JR: begin
            pcsrc   = 2'b11;
            pcwrite = 1'b1;
         end
         default: ;
      endcase
   end

   assign state   = state_q;
   // ERR only leaves through reset, so decoding it keeps the flag sticky.
   assign bus_err = (state_q == S_ERR);

endmodule
